// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit, one result bit per clock.
// Optional build macro MULDIV_EARLY_OUT_EN lets zero-operand multiplies and divide-by-zero skip the iteration.
module muldiv_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  Valid_i,
    output logic                  Ready_o,
    input  logic [2:0]            Op_i,
    input  logic [DATA_WIDTH-1:0] SrcA_i,
    input  logic [DATA_WIDTH-1:0] SrcB_i,
    input  logic                  Flush_i,
    output logic                  Valid_o,
    input  logic                  Ready_i,
    output logic [DATA_WIDTH-1:0] Result_o
);
    localparam int W         = DATA_WIDTH;
    localparam int CNT_WIDTH = $clog2(DATA_WIDTH) + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(DATA_WIDTH);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    // Handshake: a request transfers on an edge where Valid_i && Ready_o && !Flush_i;
    // a result transfers on an edge where Valid_o && Ready_i. Valid_o/Result_o hold until then.
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_next;

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [2:0]           op_q;
    logic                 neg_q, rneg_q, dz_q;
    logic [W-1:0]         opnd_q;
    logic [2*W-1:0]       acc_q;
    logic [W-1:0]         result_q;

    logic         a_signed, b_signed, a_neg, b_neg;
    logic [W-1:0] a_abs, b_abs;

    always_comb begin
        a_signed = (Op_i == 3'b001) || (Op_i == 3'b010) || (Op_i == 3'b100) || (Op_i == 3'b110);
        b_signed = (Op_i == 3'b001) || (Op_i == 3'b100) || (Op_i == 3'b110);
        a_neg    = a_signed && SrcA_i[W-1];
        b_neg    = b_signed && SrcB_i[W-1];
        a_abs    = a_neg ? -SrcA_i : SrcA_i;
        b_abs    = b_neg ? -SrcB_i : SrcB_i;
    end

    // acc_q holds {partial product, multiplier} or {partial remainder, dividend/quotient}
    logic [W:0]     mul_sum;
    logic [W:0]     div_top;
    logic [W-1:0]   div_diff;
    logic [2*W-1:0] mul_next, div_next, acc_step;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next = {mul_sum, acc_q[W-1:1]};
        div_top  = acc_q[2*W-1:W-1];
        div_diff = div_top[W-1:0] - opnd_q;
        if (div_top >= {1'b0, opnd_q})
            div_next = {div_diff, acc_q[W-2:0], 1'b1};
        else
            div_next = {div_top[W-1:0], acc_q[W-2:0], 1'b0};
        acc_step = op_q[2] ? div_next : mul_next;
    end

    // A zero divisor leaves |A| in the remainder; restoring A's sign recovers the original dividend.
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quo_fix, rem_fix, final_result;

    always_comb begin
        prod_fix = neg_q ? -acc_step : acc_step;
        quo_fix  = dz_q ? '1 : (neg_q ? -acc_step[W-1:0] : acc_step[W-1:0]);
        rem_fix  = rneg_q ? -acc_step[2*W-1:W] : acc_step[2*W-1:W];
        if (op_q[2])
            final_result = op_q[1] ? rem_fix : quo_fix;
        else if (op_q[1:0] == 2'b00)
            final_result = prod_fix[W-1:0];
        else
            final_result = prod_fix[2*W-1:W];
    end

`ifdef MULDIV_EARLY_OUT_EN
    logic         early_hit;
    logic [W-1:0] early_result;

    always_comb begin
        early_hit = Op_i[2] ? (SrcB_i == '0) : ((SrcA_i == '0) || (SrcB_i == '0));
        if (!Op_i[2])
            early_result = '0;
        else if (Op_i[1])
            early_result = SrcA_i;
        else
            early_result = '1;
    end
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        Ready_o    = 1'b0;
        Valid_o    = 1'b0;
        case (state)
            IDLE: begin
                Ready_o = 1'b1;
                if (Valid_i) begin
`ifdef MULDIV_EARLY_OUT_EN
                    state_next = early_hit ? DONE : CALC;
`else
                    state_next = CALC;
`endif
                end
            end
            CALC: if (cnt_q == CNT_ONE) state_next = DONE;
            DONE: begin
                Valid_o = 1'b1;
                if (Ready_i) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (Flush_i) state_next = IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else if (Flush_i) begin
            cnt_q <= '0;
        end else begin
            case (state)
                IDLE: if (Valid_i) begin
                    op_q   <= Op_i;
                    neg_q  <= a_neg ^ b_neg;
                    rneg_q <= a_neg;
                    dz_q   <= (SrcB_i == '0);
                    cnt_q  <= CNT_LOAD;
                    opnd_q <= Op_i[2] ? b_abs : a_abs;
                    acc_q  <= {{W{1'b0}}, (Op_i[2] ? a_abs : b_abs)};
`ifdef MULDIV_EARLY_OUT_EN
                    if (early_hit) result_q <= early_result;
`endif
                end
                CALC: begin
                    acc_q <= acc_step;
                    cnt_q <= cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) result_q <= final_result;
                end
                default: ;
            endcase
        end
    end

    assign Result_o = result_q;

endmodule
